// File: rtl/mc_alu.sv
// mc_alu: multi-cycle ALU with valid/ready handshakes on both sides.
//   Single-cycle ops (logic, add/sub, shifts, slt) complete one edge after
//   accept. Mult (radix-2 shift-add) and div (restoring) iterate W cycles in
//   BUSY. Results are held in DONE until the consumer takes them.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   in_valid / in_ready   operation handshake (ready only in IDLE)
//   a, b, ALUop, shamt    operands, opcode, shift amount
//   out_valid / out_ready result handshake (valid only in DONE)
//   r, hi, flags          result, mult high half / div remainder,
//                         {zero, carry, ovf, dz}
module mc_alu #(
  parameter int unsigned W  = 32,
  parameter int unsigned SW = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  a,
  input  logic [W-1:0]  b,
  input  logic [3:0]    ALUop,
  input  logic [SW-1:0] shamt,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  r,
  output logic [W-1:0]  hi,
  output logic [3:0]    flags
);

  localparam int unsigned CW = SW + 1;

  localparam logic [3:0] OP_NOP  = 4'b0000;
  localparam logic [3:0] OP_ADD  = 4'b0001;
  localparam logic [3:0] OP_SUB  = 4'b0010;
  localparam logic [3:0] OP_MULT = 4'b0011;
  localparam logic [3:0] OP_DIV  = 4'b0100;
  localparam logic [3:0] OP_AND  = 4'b0101;
  localparam logic [3:0] OP_OR   = 4'b0110;
  localparam logic [3:0] OP_NOR  = 4'b0111;
  localparam logic [3:0] OP_XOR  = 4'b1000;
  localparam logic [3:0] OP_NOTB = 4'b1001;
  localparam logic [3:0] OP_NAND = 4'b1010;
  localparam logic [3:0] OP_PASS = 4'b1011;
  localparam logic [3:0] OP_SLL  = 4'b1100;
  localparam logic [3:0] OP_SRL  = 4'b1101;
  localparam logic [3:0] OP_SRA  = 4'b1110;
  localparam logic [3:0] OP_SLT  = 4'b1111;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]    state_q,  state_d;
  logic [CW-1:0] cnt_q,    cnt_d;
  logic [W-1:0]  a_q,      a_d;
  logic [W-1:0]  b_q,      b_d;
  logic          is_div_q, is_div_d;
  logic [W-1:0]  acc_hi_q, acc_hi_d;   // mult: partial high half; div: remainder
  logic [W-1:0]  acc_lo_q, acc_lo_d;   // mult: multiplier/low half; div: dividend/quotient
  logic [W-1:0]  r_q,      r_d;
  logic [W-1:0]  hi_q,     hi_d;
  logic [3:0]    flags_q,  flags_d;

  // Single-cycle datapath, evaluated directly on the presented operands
  logic [W:0]   sum_c;
  logic [W-1:0] diff_c;
  logic [W-1:0] sc_r_c;
  logic         sc_cy_c;
  logic         sc_ov_c;
  logic [3:0]   sc_flags_c;

  always_comb begin
    sum_c   = {1'b0, a} + {1'b0, b};
    diff_c  = a - b;
    sc_r_c  = '0;
    sc_cy_c = 1'b0;
    sc_ov_c = 1'b0;
    case (ALUop)
      OP_ADD: begin
        sc_r_c  = sum_c[W-1:0];
        sc_cy_c = sum_c[W];
        sc_ov_c = (a[W-1] == b[W-1]) && (sum_c[W-1] != a[W-1]);
      end
      OP_SUB: begin
        sc_r_c  = diff_c;
        sc_cy_c = (a < b);
        sc_ov_c = (a[W-1] != b[W-1]) && (diff_c[W-1] != a[W-1]);
      end
      OP_AND:  sc_r_c = a & b;
      OP_OR:   sc_r_c = a | b;
      OP_NOR:  sc_r_c = ~(a | b);
      OP_XOR:  sc_r_c = a ^ b;
      OP_NOTB: sc_r_c = ~b;
      OP_NAND: sc_r_c = ~(a & b);
      OP_PASS: sc_r_c = b;
      OP_SLL:  sc_r_c = a << shamt;
      OP_SRL:  sc_r_c = a >> shamt;
      OP_SRA:  sc_r_c = $unsigned($signed(a) >>> shamt);
      OP_SLT:  sc_r_c = W'(a < b);
      default: sc_r_c = '0;
    endcase
    // The no-op code reports all-zero flags, including zero
    if (ALUop == OP_NOP) sc_flags_c = 4'b0000;
    else                 sc_flags_c = {(sc_r_c == '0), sc_cy_c, sc_ov_c, 1'b0};
  end

  // One shift-add multiply step: add multiplicand when the multiplier LSB is set,
  // then shift the {hi, lo} pair right by one.
  logic [W:0]   mul_sum_c;
  logic [W-1:0] mul_hi_c;
  logic [W-1:0] mul_lo_c;

  always_comb begin
    if (acc_lo_q[0]) mul_sum_c = {1'b0, acc_hi_q} + {1'b0, a_q};
    else             mul_sum_c = {1'b0, acc_hi_q};
    mul_hi_c = mul_sum_c[W:1];
    mul_lo_c = {mul_sum_c[0], acc_lo_q[W-1:1]};
  end

  // One restoring divide step: shift next dividend bit into the remainder,
  // subtract the divisor when it fits. The shifted remainder is < 2*b, so W+1 bits suffice.
  logic [W:0]   div_sh_c;
  logic         div_ge_c;
  logic [W-1:0] div_rem_c;
  logic [W-1:0] div_quo_c;

  always_comb begin
    div_sh_c = {acc_hi_q, acc_lo_q[W-1]};
    div_ge_c = (div_sh_c >= {1'b0, b_q});
    if (div_ge_c) div_rem_c = W'(div_sh_c - {1'b0, b_q});
    else          div_rem_c = div_sh_c[W-1:0];
    div_quo_c = {acc_lo_q[W-2:0], div_ge_c};
  end

  // Next-state and result logic
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    is_div_d = is_div_q;
    acc_hi_d = acc_hi_q;
    acc_lo_d = acc_lo_q;
    r_d      = r_q;
    hi_d     = hi_q;
    flags_d  = flags_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          if (ALUop == OP_MULT || ALUop == OP_DIV) begin
            state_d  = S_BUSY;
            cnt_d    = CW'(W);
            a_d      = a;
            b_d      = b;
            is_div_d = (ALUop == OP_DIV);
            acc_hi_d = '0;
            acc_lo_d = (ALUop == OP_DIV) ? a : b;
          end else begin
            state_d = S_DONE;
            r_d     = sc_r_c;
            hi_d    = '0;
            flags_d = sc_flags_c;
          end
        end
      end
      S_BUSY: begin
        if (cnt_q != '0) cnt_d = cnt_q - CW'(1);
        if (is_div_q) begin
          acc_hi_d = div_rem_c;
          acc_lo_d = div_quo_c;
        end else begin
          acc_hi_d = mul_hi_c;
          acc_lo_d = mul_lo_c;
        end
        // Last iteration: publish the step result directly
        if (cnt_q <= CW'(1)) begin
          state_d = S_DONE;
          if (is_div_q) begin
            if (b_q == '0) begin
              r_d     = '1;
              hi_d    = a_q;
              flags_d = 4'b0001;
            end else begin
              r_d     = div_quo_c;
              hi_d    = div_rem_c;
              flags_d = {(div_quo_c == '0), 3'b000};
            end
          end else begin
            r_d     = mul_lo_c;
            hi_d    = mul_hi_c;
            flags_d = {(mul_lo_c == '0), 1'b0, (mul_hi_c != '0), 1'b0};
          end
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      is_div_q <= 1'b0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      r_q      <= '0;
      hi_q     <= '0;
      flags_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      is_div_q <= is_div_d;
      acc_hi_q <= acc_hi_d;
      acc_lo_q <= acc_lo_d;
      r_q      <= r_d;
      hi_q     <= hi_d;
      flags_q  <= flags_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign r         = r_q;
  assign hi        = hi_q;
  assign flags     = flags_q;

endmodule

// File: tb/tb_mc_alu.sv
// Directed bench for mc_alu (W=32): handshakes, latency, results, flags,
// hold behaviour and reset abort.
module tb_mc_alu;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic [3:0]  ALUop;
  logic [4:0]  shamt;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] r;
  logic [31:0] hi;
  logic [3:0]  flags;

  int total;
  int bad;

  mc_alu #(.W(32), .SW(5)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .ALUop     (ALUop),
    .shamt     (shamt),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .r         (r),
    .hi        (hi),
    .flags     (flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Present one op, return the number of edges (accept edge included) until out_valid
  task automatic run_op(input logic [3:0] op, input logic [31:0] av, input logic [31:0] bv,
                        input logic [4:0] sh, output int lat);
    @(negedge clk);
    in_valid = 1'b1;
    ALUop    = op;
    a        = av;
    b        = bv;
    shamt    = sh;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a        = ~av;
    b        = ~bv;
    shamt    = ~sh;
    ALUop    = 4'b0001;
    lat      = 1;
    while (!out_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  // Consume the result and confirm return to IDLE
  task automatic take(input string tag);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check({tag, "_vld_drop"}, 64'(out_valid), 64'd0);
    check({tag, "_rdy_back"}, 64'(in_ready), 64'd1);
  endtask

  task automatic do_test(input string tag, input logic [3:0] op, input logic [31:0] av,
                         input logic [31:0] bv, input logic [4:0] sh, input int lat_exp,
                         input logic [31:0] r_exp, input logic [31:0] hi_exp,
                         input logic [3:0] fl_exp);
    int lat;
    run_op(op, av, bv, sh, lat);
    check({tag, "_lat"}, 64'(lat), 64'(lat_exp));
    check({tag, "_r"}, 64'(r), 64'(r_exp));
    check({tag, "_hi"}, 64'(hi), 64'(hi_exp));
    check({tag, "_flags"}, 64'(flags), 64'(fl_exp));
    take(tag);
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    ALUop     = '0;
    shamt     = '0;

    repeat (2) @(negedge clk);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_r", 64'(r), 64'd0);
    check("rst_hi", 64'(hi), 64'd0);
    check("rst_flags", 64'(flags), 64'd0);
    rst_n = 1'b1;

    // flags = {zero, carry, ovf, dz}
    do_test("add_wrap", 4'b0001, 32'hFFFF_FFFF, 32'h1, 5'd0, 1, 32'h0, 32'h0, 4'b1100);
    do_test("add_ovf",  4'b0001, 32'h7FFF_FFFF, 32'h1, 5'd0, 1, 32'h8000_0000, 32'h0, 4'b0010);
    do_test("sub_brw",  4'b0010, 32'h3, 32'h5, 5'd0, 1, 32'hFFFF_FFFE, 32'h0, 4'b0100);
    do_test("sub_ovf",  4'b0010, 32'h8000_0000, 32'h1, 5'd0, 1, 32'h7FFF_FFFF, 32'h0, 4'b0010);
    do_test("mul_big",  4'b0011, 32'h0001_0000, 32'h0001_0000, 5'd0, 33, 32'h0, 32'h1, 4'b1010);
    do_test("add_hi0",  4'b0001, 32'h1, 32'h1, 5'd0, 1, 32'h2, 32'h0, 4'b0000);
    do_test("mul_small",4'b0011, 32'h1234_5678, 32'h9, 5'd0, 33, 32'hA3D7_0A38, 32'h0, 4'b0000);
    do_test("div_100_7",4'b0100, 32'd100, 32'd7, 5'd0, 33, 32'd14, 32'd2, 4'b0000);
    do_test("div_zero", 4'b0100, 32'd5, 32'd0, 5'd0, 33, 32'hFFFF_FFFF, 32'd5, 4'b0001);
    do_test("and",  4'b0101, 32'hF0F0_FF00, 32'h0FF0_F0F0, 5'd0, 1, 32'h00F0_F000, 32'h0, 4'b0000);
    do_test("or",   4'b0110, 32'hF0F0_FF00, 32'h0FF0_F0F0, 5'd0, 1, 32'hFFF0_FFF0, 32'h0, 4'b0000);
    do_test("nor",  4'b0111, 32'hF0F0_FF00, 32'h0FF0_F0F0, 5'd0, 1, 32'h000F_000F, 32'h0, 4'b0000);
    do_test("xor",  4'b1000, 32'hF0F0_FF00, 32'h0FF0_F0F0, 5'd0, 1, 32'hFF00_0FF0, 32'h0, 4'b0000);
    do_test("notb", 4'b1001, 32'hF0F0_FF00, 32'h0FF0_F0F0, 5'd0, 1, 32'hF00F_0F0F, 32'h0, 4'b0000);
    do_test("nand", 4'b1010, 32'hF0F0_FF00, 32'h0FF0_F0F0, 5'd0, 1, 32'hFF0F_0FFF, 32'h0, 4'b0000);
    do_test("passb",4'b1011, 32'hF0F0_FF00, 32'h0FF0_F0F0, 5'd0, 1, 32'h0FF0_F0F0, 32'h0, 4'b0000);
    do_test("sll4", 4'b1100, 32'h8000_0001, 32'h0, 5'd4, 1, 32'h0000_0010, 32'h0, 4'b0000);
    do_test("srl4", 4'b1101, 32'h8000_0001, 32'h0, 5'd4, 1, 32'h0800_0000, 32'h0, 4'b0000);
    do_test("sra4", 4'b1110, 32'h8000_0001, 32'h0, 5'd4, 1, 32'hF800_0000, 32'h0, 4'b0000);
    do_test("sra31",4'b1110, 32'h8000_0000, 32'h0, 5'd31, 1, 32'hFFFF_FFFF, 32'h0, 4'b0000);
    do_test("sll0", 4'b1100, 32'h8000_0001, 32'hFF, 5'd0, 1, 32'h8000_0001, 32'h0, 4'b0000);
    do_test("nop",  4'b0000, 32'h1234, 32'h5678, 5'd3, 1, 32'h0, 32'h0, 4'b0000);
    do_test("slt_t",4'b1111, 32'd3, 32'd5, 5'd0, 1, 32'h1, 32'h0, 4'b0000);
    do_test("slt_f",4'b1111, 32'd5, 32'd3, 5'd0, 1, 32'h0, 32'h0, 4'b1000);

    // Hold result for 10 cycles with a stray in_valid pulse in the window
    begin
      int lat;
      run_op(4'b0001, 32'd10, 32'd20, 5'd0, lat);
      check("hold_lat", 64'(lat), 64'd1);
      for (int i = 0; i < 10; i++) begin
        @(negedge clk);
        in_valid = (i == 4);
        ALUop    = 4'b0010;
        a        = 32'd1;
        b        = 32'd1;
        @(posedge clk);
        #1;
        check("hold_r", 64'(r), 64'd30);
        check("hold_flags", 64'(flags), 64'd0);
        check("hold_vld", 64'(out_valid), 64'd1);
        check("hold_rdy", 64'(in_ready), 64'd0);
      end
      in_valid = 1'b0;
      take("hold");
      repeat (2) @(posedge clk);
      #1;
      check("hold_no_second", 64'(out_valid), 64'd0);
    end

    // Reset in the 10th BUSY cycle of a mult aborts it
    @(negedge clk);
    in_valid = 1'b1;
    ALUop    = 4'b0011;
    a        = 32'd7;
    b        = 32'd9;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_vld", 64'(out_valid), 64'd0);
    check("abort_rdy", 64'(in_ready), 64'd1);
    check("abort_r", 64'(r), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    check("abort_no_result", 64'(out_valid), 64'd0);
    do_test("post_rst_add", 4'b0001, 32'd2, 32'd3, 5'd0, 1, 32'd5, 32'h0, 4'b0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
